// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern filler and pattern checker:
// pattern-type codes, fill words, checker state encoding and the
// expected-word function that maps (pattern, block, word) to 32 bits.
package pattern_pkg;

  localparam logic [1:0] PAT_INCR = 2'd0;
  localparam logic [1:0] PAT_DECR = 2'd1;
  localparam logic [1:0] PAT_0F   = 2'd2;
  localparam logic [1:0] PAT_5A   = 2'd3;

  localparam logic [31:0] FILL_ZERO = 32'h0000_0000;
  localparam logic [31:0] FILL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] FILL_FIVE = 32'h5555_5555;
  localparam logic [31:0] FILL_AAAA = 32'hAAAA_AAAA;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_RUN   = 2'd1,
    CHK_DRAIN = 2'd2
  } chk_state_t;

  // Word value for block blk, word wrd. DECR is the bitwise complement of
  // INCR, which equals 0xFFFF_FFFF minus the INCR value modulo 2^32.
  function automatic logic [31:0] pat_word(input logic [1:0]  pat,
                                           input logic [15:0] blk,
                                           input logic [31:0] wrd);
    logic [31:0] lin;
    lin = {blk, 16'h0000} + wrd;
    case (pat)
      PAT_INCR: pat_word = lin;
      PAT_DECR: pat_word = ~lin;
      PAT_0F:   pat_word = wrd[1] ? FILL_ONES : FILL_ZERO;
      default:  pat_word = wrd[1] ? FILL_AAAA : FILL_FIVE;
    endcase
  endfunction

endpackage

// File: rtl/pattern_expect_gen.sv
// Expected-word generator: holds the latched pattern type, the word and
// block position and the registered expected word. init restarts at
// block 0 word 0 with the current pattern input; advance steps one word.
module pattern_expect_gen
  import pattern_pkg::*;
#(
  parameter int BLK_AW = 16
) (
  input  logic        digiclk,
  input  logic        resetn,
  input  logic        init,
  input  logic        advance,
  input  logic [1:0]  pattern,
  output logic [31:0] exp_word,
  output logic [15:0] blk_idx
);

  logic [1:0]        pat_q;
  logic [BLK_AW-1:0] w_q;
  logic [BLK_AW-1:0] w_nxt;
  logic [15:0]       b_q;
  logic [15:0]       b_nxt;

  // Next position: word wraps at the block end and carries into the block.
  always_comb begin
    w_nxt = w_q + 1'b1;
    b_nxt = (w_q == '1) ? b_q + 16'd1 : b_q;
  end

  // Position counters and expected word for the upcoming compare.
  always_ff @(posedge digiclk or negedge resetn) begin
    if (!resetn) begin
      pat_q    <= PAT_INCR;
      w_q      <= '0;
      b_q      <= '0;
      exp_word <= '0;
    end else if (init) begin
      pat_q    <= pattern;
      w_q      <= '0;
      b_q      <= '0;
      exp_word <= pat_word(pattern, 16'd0, 32'd0);
    end else if (advance) begin
      w_q      <= w_nxt;
      b_q      <= b_nxt;
      exp_word <= pat_word(pat_q, b_nxt, 32'(w_nxt));
    end
  end

  assign blk_idx = b_q;

endmodule

// File: rtl/pattern_fifo_checker.sv
// Readout-side pattern checker: drains the readout FIFO, regenerates the
// expected pattern word by word and reports mismatch, word and block
// counts. Optional macro PATTERN_CHK_FIRSTERR_EN builds the first-error
// capture registers; without it those outputs are tied to zero.
module pattern_fifo_checker
  import pattern_pkg::*;
#(
  parameter int BLK_AW = 16
) (
  input  logic        digiclk,
  input  logic        resetn,
  input  logic [1:0]  pattern,
  input  logic        check_start,
  input  logic        check_stop,
  input  logic        rd_empty,
  input  logic [31:0] rd_data,
  output logic        rd_en,
  output logic        chk_busy,
  output logic        err_flag,
  output logic [31:0] err_cnt,
  output logic [31:0] word_cnt,
  output logic [15:0] blk_cnt,
  output logic [31:0] first_err_data,
  output logic [31:0] first_err_exp,
  output logic [31:0] first_err_idx
);

  chk_state_t  state_q;
  chk_state_t  state_nxt;
  logic        start_acc;
  logic        vld_p1;
  logic        mis_p1;
  logic [31:0] exp_p1;

  // State register.
  always_ff @(posedge digiclk or negedge resetn) begin
    if (!resetn) state_q <= CHK_IDLE;
    else         state_q <= state_nxt;
  end

  // Next state and read enable; stop wins over start while running.
  always_comb begin
    state_nxt = state_q;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      CHK_IDLE: begin
        if (check_start) begin
          start_acc = 1'b1;
          state_nxt = CHK_RUN;
        end
      end
      CHK_RUN: begin
        rd_en = !rd_empty;
        if (check_stop) state_nxt = CHK_DRAIN;
      end
      CHK_DRAIN: state_nxt = CHK_IDLE;
      default:   state_nxt = CHK_IDLE;
    endcase
  end

  assign chk_busy = (state_q != CHK_IDLE);

  // ---- stage p1: read data returns one cycle after rd_en ----
  // Track which cycle carries valid FIFO data.
  always_ff @(posedge digiclk or negedge resetn) begin
    if (!resetn) vld_p1 <= 1'b0;
    else         vld_p1 <= rd_en;
  end

  pattern_expect_gen #(
    .BLK_AW (BLK_AW)
  ) u_exp (
    .digiclk  (digiclk),
    .resetn   (resetn),
    .init     (start_acc),
    .advance  (vld_p1),
    .pattern  (pattern),
    .exp_word (exp_p1),
    .blk_idx  (blk_cnt)
  );

  assign mis_p1 = vld_p1 && (rd_data != exp_p1);

  // ---- stage p2: compare result lands in the status registers ----
  // Word and error counters with sticky error flag.
  always_ff @(posedge digiclk or negedge resetn) begin
    if (!resetn) begin
      word_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (start_acc) begin
      word_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (vld_p1) begin
      word_cnt <= word_cnt + 32'd1;
      if (mis_p1) begin
        err_flag <= 1'b1;
        if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
      end
    end
  end

`ifdef PATTERN_CHK_FIRSTERR_EN
  // Capture the first mismatch of a run only.
  always_ff @(posedge digiclk or negedge resetn) begin
    if (!resetn) begin
      first_err_data <= '0;
      first_err_exp  <= '0;
      first_err_idx  <= '0;
    end else if (start_acc) begin
      first_err_data <= '0;
      first_err_exp  <= '0;
      first_err_idx  <= '0;
    end else if (mis_p1 && !err_flag) begin
      first_err_data <= rd_data;
      first_err_exp  <= exp_p1;
      first_err_idx  <= word_cnt;
    end
  end
`else
  assign first_err_data = '0;
  assign first_err_exp  = '0;
  assign first_err_idx  = '0;
`endif

endmodule
